fu_issue_arbiter: RTL and testbench
===================================

# fu_issue_arbiter

Per-wavefront functional-unit reader and issue arbiter. It consumes the four one-hot-per-wavefront FU-type vectors held by the issue stage (`fu_simd`, `fu_simf`, `fu_salu`, `fu_lsu`) together with per-wavefront readiness. For each FU lane it selects one wavefront round-robin and offers it to that FU over a valid/ack handshake. It sits between the FU-type register bank and the four execution units, and reports completed issues back so upstream can clear readiness.

## Interface
- `WF_PER_CU`, 40: wavefronts per compute unit (from `global_definitions.v`).
- `WF_ID_LENGTH`, 6: wavefront ID width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `fu_simd`, `fu_simf`, `fu_salu`, `fu_lsu`  in  `WF_PER_CU` each  FU-type membership per wavefront; at most one vector has a given bit set.
- `wf_ready`  in  `WF_PER_CU`  wavefront has an instruction ready to issue.
- `<lane>_ack`  in  1 per lane (simd/simf/salu/lsu)  FU accepts the current offer.
- `<lane>_valid`  out  1 per lane  offer valid.
- `<lane>_wfid`  out  `WF_ID_LENGTH` per lane  offered wavefront.
- `wf_issued`  out  `WF_PER_CU`  one-cycle pulse, bit set per accepted wavefront.
- `<lane>_stall_cnt`  out  16 per lane  stall counters (see Configuration).

## Operation
- Four identical, independent lanes. Each lane has a 2-state FSM (IDLE, OFFER), a round-robin pointer `ptr` in 0..39, and registered `valid`/`wfid`.
- Shared `issued_mask[39:0]`:
  - bit sets on an accepted handshake for that wavefront;
  - bit clears in any cycle where `wf_ready` for that bit is 0;
  - set wins if both happen in the same cycle.
- Lane candidate vector = `wf_ready & fu_<lane> & ~issued_mask & ~acked_this_cycle`.
- Pick rule: the lowest index ≥ `ptr`; if none, wrap and take the lowest index < `ptr`.
- IDLE: if any candidate exists, load `wfid` = pick, `valid` = 1, go to OFFER. Otherwise stay.
- OFFER:
  - `valid` and `wfid` are held stable until `ack`; changes on `wf_ready`/`fu_*` never retract or alter an offer.
  - On `ack`: `ptr` = `wfid`+1, with 39 wrapping to 0. Set `wf_issued[wfid]` next cycle.
  - In the same cycle, re-pick using the updated pointer and a candidate set excluding the acked ID. If a pick exists, stay in OFFER with the new `wfid` (back-to-back). Otherwise clear `valid` and go to IDLE.
- `ack` while `valid` = 0 is ignored.
- A wavefront whose bit is set in more than one `fu_*` vector is a protocol violation; the result is undefined.

## Timing
- Reset values: all `valid` = 0, `wfid` = 0, `ptr` = 0, `issued_mask` = 0, `wf_issued` = 0, stall counters = 0. Reset during OFFER drops the offer at the next edge; no `wf_issued` pulse is produced.
- Latency: candidate appears in cycle N → `valid` in N+1.
- Throughput: `ack` in cycle M → `wf_issued` pulse in M+1; the next offer is also valid in M+1, giving one issue per lane per cycle.
- Upstream must deassert `wf_ready` for an issued wavefront no later than one cycle after its `wf_issued` pulse. Until then, `issued_mask` blocks re-selection.
- Lanes never conflict, because the FU vectors are disjoint. Simultaneous acks on all four lanes produce up to four bits in one `wf_issued` pulse.

## Configuration
- `FU_ISSUE_STALL_CNT_EN` defined:
  - each lane's `<lane>_stall_cnt` increments in every cycle where `valid` = 1 and `ack` = 0;
  - the counter saturates at 0xFFFF and clears only on `rst`.
- `FU_ISSUE_STALL_CNT_EN` undefined: no counter logic is built; `<lane>_stall_cnt` is tied to 0. The ports are present in both builds.

## Structure
- Shared package/definitions:
  - `WF_PER_CU` and `WF_ID_LENGTH` (`global_definitions.v`);
  - lane FSM encodings `FUARB_IDLE` = 0 and `FUARB_OFFER` = 1;
  - `FUARB_STALL_W` = 16 (`issue_definitions.v`).
- One sub-module, `fu_issue_lane`: FSM, pointer, round-robin pick, and stall counter. It is instantiated four times.
- The top level owns `issued_mask`, `wf_issued`, and the combined ack masking.

## Test plan
- Reset, then `wf_ready` bits 3 and 10 set with `fu_simd` bits 3 and 10 set, `simd_ack` tied to 1 → `simd_valid` rises 1 cycle later with `wfid` 3, then `wfid` 10 on the next cycle; `wf_issued` bit 3 pulses, then bit 10; `ptr` ends at 11.
- Wrap-around: `ptr` = 39, ready SALU wavefronts {39, 0, 5}, ack every cycle → issue order 39, 0, 5.
- Hold: `lsu_valid` with `wfid` 7, `lsu_ack` = 0 for 5 cycles while `wf_ready[7]` drops → `wfid` stays 7 for all 5 cycles; with `FU_ISSUE_STALL_CNT_EN` defined, `lsu_stall_cnt` = 5.
- No re-issue: SIMF `wfid` 12 acked, `wf_ready[12]` held high for 1 extra cycle → 12 is not offered again; the lane goes IDLE.
- Simultaneous: ready wavefronts 1 (SIMD), 2 (SIMF), 3 (SALU), 4 (LSU), all acks high → all four lanes are valid in the same cycle; `wf_issued` = 0x1E in one pulse.
- Reset mid-offer: `rst` asserted for 1 cycle during a SIMD offer → `simd_valid` = 0, no `wf_issued` pulse, and the first offer after reset comes from `ptr` 0.

Source files
------------

// File: rtl/fu_issue_arbiter_pkg.sv
// Shared definitions for the FU issue arbiter: sizes, lane FSM encoding, round-robin pick helper.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package fu_issue_arbiter_pkg;

    localparam int WF_PER_CU     = 40;
    localparam int WF_ID_LENGTH  = 6;
    localparam int FUARB_STALL_W = 16;
    localparam int FUARB_LANES   = 4;

    typedef logic [WF_PER_CU-1:0]     wf_vec_t;
    typedef logic [WF_ID_LENGTH-1:0]  wf_id_t;
    typedef logic [FUARB_STALL_W-1:0] stall_cnt_t;

    typedef enum logic {
        FUARB_IDLE  = 1'b0,
        FUARB_OFFER = 1'b1
    } fuarb_state_t;

    typedef struct packed {
        logic   found;
        wf_id_t idx;
    } pick_t;

    // Lowest candidate at or above ptr; otherwise the lowest candidate overall (wrap).
    function automatic pick_t rr_pick(input wf_vec_t cand, input wf_id_t ptr);
        pick_t lo;
        pick_t hi;
        lo = '0;
        hi = '0;
        for (int i = WF_PER_CU - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo = '{found: 1'b1, idx: wf_id_t'(i)};
                if (wf_id_t'(i) >= ptr) begin
                    hi = '{found: 1'b1, idx: wf_id_t'(i)};
                end
            end
        end
        return hi.found ? hi : lo;
    endfunction

    function automatic wf_vec_t wf_onehot(input wf_id_t id);
        return wf_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Issue-stage bundle: FU-type vectors and readiness in, per-lane valid/ack offers and issue pulses out.
// Latency: n/a (wires only).
// Backpressure: each lane's offer is held until its ack.
interface fu_issue_arbiter_if;
    import fu_issue_arbiter_pkg::*;

    wf_vec_t    fu_simd, fu_simf, fu_salu, fu_lsu;
    wf_vec_t    wf_ready;
    logic       simd_ack, simf_ack, salu_ack, lsu_ack;
    logic       simd_valid, simf_valid, salu_valid, lsu_valid;
    wf_id_t     simd_wfid, simf_wfid, salu_wfid, lsu_wfid;
    wf_vec_t    wf_issued;
    stall_cnt_t simd_stall_cnt, simf_stall_cnt, salu_stall_cnt, lsu_stall_cnt;

    modport master (
        output fu_simd, fu_simf, fu_salu, fu_lsu, wf_ready,
        output simd_ack, simf_ack, salu_ack, lsu_ack,
        input  simd_valid, simf_valid, salu_valid, lsu_valid,
        input  simd_wfid, simf_wfid, salu_wfid, lsu_wfid,
        input  wf_issued,
        input  simd_stall_cnt, simf_stall_cnt, salu_stall_cnt, lsu_stall_cnt
    );

    modport slave (
        input  fu_simd, fu_simf, fu_salu, fu_lsu, wf_ready,
        input  simd_ack, simf_ack, salu_ack, lsu_ack,
        output simd_valid, simf_valid, salu_valid, lsu_valid,
        output simd_wfid, simf_wfid, salu_wfid, lsu_wfid,
        output wf_issued,
        output simd_stall_cnt, simf_stall_cnt, salu_stall_cnt, lsu_stall_cnt
    );

endinterface

// File: rtl/fu_issue_arbiter_lane.sv
// One FU lane: round-robin pick over its candidates, offer held until ack; stall counter if FU_ISSUE_STALL_CNT_EN.
// Latency: candidate in cycle N -> valid in N+1; ack in M -> next offer in M+1.
// Backpressure: valid/wfid frozen while ack is low.
module fu_issue_lane
    import fu_issue_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  wf_vec_t    cand,
    input  logic       ack,
    output logic       valid,
    output wf_id_t     wfid,
    output stall_cnt_t stall_cnt
);

    fuarb_state_t state, state_nxt;
    wf_id_t       wfid_nxt;
    wf_id_t       ptr, ptr_sel;
    logic         fire;
    pick_t        pick;

    assign valid = (state == FUARB_OFFER);

    always_comb begin
        fire      = valid && ack;
        ptr_sel   = ptr;
        if (fire) begin
            ptr_sel = (wfid == wf_id_t'(WF_PER_CU - 1)) ? '0 : wfid + wf_id_t'(1);
        end
        // The pointer update and the re-pick share a cycle so back-to-back issue needs no bubble.
        pick      = rr_pick(cand, ptr_sel);
        state_nxt = state;
        wfid_nxt  = wfid;
        case (state)
            FUARB_IDLE: begin
                if (pick.found) begin
                    state_nxt = FUARB_OFFER;
                    wfid_nxt  = pick.idx;
                end
            end
            FUARB_OFFER: begin
                if (ack) begin
                    if (pick.found) begin
                        wfid_nxt = pick.idx;
                    end else begin
                        state_nxt = FUARB_IDLE;
                    end
                end
            end
            default: state_nxt = FUARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FUARB_IDLE;
            wfid  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            wfid  <= wfid_nxt;
            ptr   <= ptr_sel;
        end
    end

`ifdef FU_ISSUE_STALL_CNT_EN
    stall_cnt_t stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (valid && !ack && stall_q != '1) begin
            stall_q <= stall_q + stall_cnt_t'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: rtl/fu_issue_arbiter.sv
// Per-wavefront FU issue arbiter: four round-robin lanes plus shared issued mask (stall counters under FU_ISSUE_STALL_CNT_EN).
// Latency: ready candidate -> offer 1 cycle; ack -> wf_issued pulse 1 cycle.
// Backpressure: offers held until ack; issued_mask blocks re-selection until wf_ready drops.
module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fu_issue_arbiter_if.slave  bus
);

    wf_vec_t                      fu   [FUARB_LANES];
    wf_vec_t                      cand [FUARB_LANES];
    logic       [FUARB_LANES-1:0] ack;
    logic       [FUARB_LANES-1:0] lane_valid;
    wf_id_t                       lane_wfid  [FUARB_LANES];
    stall_cnt_t                   lane_stall [FUARB_LANES];
    wf_vec_t                      acked;
    wf_vec_t                      issued_mask;
    wf_vec_t                      wf_issued_q;

    assign fu[0] = bus.fu_simd;
    assign fu[1] = bus.fu_simf;
    assign fu[2] = bus.fu_salu;
    assign fu[3] = bus.fu_lsu;
    assign ack   = {bus.lsu_ack, bus.salu_ack, bus.simf_ack, bus.simd_ack};

    always_comb begin
        acked = '0;
        for (int l = 0; l < FUARB_LANES; l++) begin
            if (lane_valid[l] && ack[l]) begin
                acked = acked | wf_onehot(lane_wfid[l]);
            end
        end
    end

    for (genvar l = 0; l < FUARB_LANES; l++) begin : g_lane
        assign cand[l] = bus.wf_ready & fu[l] & ~issued_mask & ~acked;

        fu_issue_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .cand      (cand[l]),
            .ack       (ack[l]),
            .valid     (lane_valid[l]),
            .wfid      (lane_wfid[l]),
            .stall_cnt (lane_stall[l])
        );
    end

    // A fresh accept outranks a same-cycle ready drop for that wavefront.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_mask <= '0;
            wf_issued_q <= '0;
        end else begin
            issued_mask <= acked | (issued_mask & bus.wf_ready);
            wf_issued_q <= acked;
        end
    end

    assign bus.wf_issued      = wf_issued_q;
    assign bus.simd_valid     = lane_valid[0];
    assign bus.simf_valid     = lane_valid[1];
    assign bus.salu_valid     = lane_valid[2];
    assign bus.lsu_valid      = lane_valid[3];
    assign bus.simd_wfid      = lane_wfid[0];
    assign bus.simf_wfid      = lane_wfid[1];
    assign bus.salu_wfid      = lane_wfid[2];
    assign bus.lsu_wfid       = lane_wfid[3];
    assign bus.simd_stall_cnt = lane_stall[0];
    assign bus.simf_stall_cnt = lane_stall[1];
    assign bus.salu_stall_cnt = lane_stall[2];
    assign bus.lsu_stall_cnt  = lane_stall[3];

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: table vectors, directed corner sequences, and random traffic vs. a reference model.
module tb_fu_issue_arbiter;
    import fu_issue_arbiter_pkg::*;

`ifdef FU_ISSUE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [3:0][39:0]     fu_v;
    logic [39:0]          ready;
    logic [3:0]           ack_v;
    int                   n_vec;
    int                   n_bad;

    fu_issue_arbiter_if bus ();

    assign bus.fu_simd  = fu_v[0];
    assign bus.fu_simf  = fu_v[1];
    assign bus.fu_salu  = fu_v[2];
    assign bus.fu_lsu   = fu_v[3];
    assign bus.wf_ready = ready;
    assign bus.simd_ack = ack_v[0];
    assign bus.simf_ack = ack_v[1];
    assign bus.salu_ack = ack_v[2];
    assign bus.lsu_ack  = ack_v[3];

    fu_issue_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [3:0]  d_valid;
    logic [5:0]  d_wfid  [4];
    logic [15:0] d_stall [4];
    assign d_valid  = {bus.lsu_valid, bus.salu_valid, bus.simf_valid, bus.simd_valid};
    assign d_wfid[0] = bus.simd_wfid;
    assign d_wfid[1] = bus.simf_wfid;
    assign d_wfid[2] = bus.salu_wfid;
    assign d_wfid[3] = bus.lsu_wfid;
    assign d_stall[0] = bus.simd_stall_cnt;
    assign d_stall[1] = bus.simf_stall_cnt;
    assign d_stall[2] = bus.salu_stall_cnt;
    assign d_stall[3] = bus.lsu_stall_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: circular search from the pointer over a plain bit array.
    bit          m_valid [4];
    int          m_id    [4];
    int          m_ptr   [4];
    int          m_stall [4];
    bit [39:0]   m_mask;
    bit [39:0]   m_issued;

    always @(posedge clk) begin
        bit [39:0] acked;
        bit        fired;
        bit        found;
        int        sel;
        int        idx;
        if (rst) begin
            for (int l = 0; l < 4; l++) begin
                m_valid[l] = 0; m_id[l] = 0; m_ptr[l] = 0; m_stall[l] = 0;
            end
            m_mask   = '0;
            m_issued = '0;
        end else begin
            acked = '0;
            for (int l = 0; l < 4; l++)
                if (m_valid[l] && ack_v[l]) acked[m_id[l]] = 1'b1;
            for (int l = 0; l < 4; l++) begin
                if (STALL_EN && m_valid[l] && !ack_v[l] && m_stall[l] < 65535)
                    m_stall[l]++;
                fired = m_valid[l] && ack_v[l];
                if (fired) m_ptr[l] = (m_id[l] + 1) % 40;
                if (!m_valid[l] || fired) begin
                    found = 0;
                    sel   = 0;
                    for (int k = 0; k < 40; k++) begin
                        idx = (m_ptr[l] + k) % 40;
                        if (!found && ready[idx] && fu_v[l][idx] && !m_mask[idx] && !acked[idx]) begin
                            found = 1;
                            sel   = idx;
                        end
                    end
                    m_valid[l] = found;
                    if (found) m_id[l] = sel;
                end
            end
            m_issued = acked;
            m_mask   = acked | (m_mask & ready);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("mdl_valid[%0d]", l), 64'(d_valid[l]), 64'(m_valid[l]));
            chk($sformatf("mdl_wfid[%0d]", l), 64'(d_wfid[l]), 64'(m_id[l]));
            chk($sformatf("mdl_stall[%0d]", l), 64'(d_stall[l]), 64'(m_stall[l]));
        end
        chk("mdl_issued", 64'(bus.wf_issued), 64'(m_issued));
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = '0; ack_v = '0; fu_v = '0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [39:0] ready;
        logic [3:0]  ack;
        logic [3:0]  exp_valid;
        logic [5:0]  exp_wfid;
        logic [39:0] exp_issued;
    } vec_t;

    vec_t tbl [13];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        ready = '0;
        ack_v = '0;
        fu_v  = '0;

        // SIMD lane on wavefronts {3,10,12}: back-to-back, pointer at 11, hold, reset mid-offer.
        tbl[0]  = '{1'b1, 40'h0,    4'h0, 4'h0, 6'd0,  40'h0};
        tbl[1]  = '{1'b0, 40'h408,  4'h1, 4'h1, 6'd3,  40'h0};
        tbl[2]  = '{1'b0, 40'h408,  4'h1, 4'h1, 6'd10, 40'h8};
        tbl[3]  = '{1'b0, 40'h408,  4'h1, 4'h0, 6'd10, 40'h400};
        tbl[4]  = '{1'b0, 40'h408,  4'h1, 4'h0, 6'd10, 40'h0};
        tbl[5]  = '{1'b0, 40'h0,    4'h0, 4'h0, 6'd10, 40'h0};
        tbl[6]  = '{1'b0, 40'h1408, 4'h0, 4'h1, 6'd12, 40'h0};
        tbl[7]  = '{1'b0, 40'h1408, 4'h0, 4'h1, 6'd12, 40'h0};
        tbl[8]  = '{1'b1, 40'h1408, 4'h1, 4'h0, 6'd0,  40'h0};
        tbl[9]  = '{1'b0, 40'h1408, 4'h0, 4'h1, 6'd3,  40'h0};
        tbl[10] = '{1'b0, 40'h1408, 4'h1, 4'h1, 6'd10, 40'h8};
        tbl[11] = '{1'b0, 40'h0,    4'h0, 4'h1, 6'd10, 40'h0};
        tbl[12] = '{1'b1, 40'h0,    4'h0, 4'h0, 6'd0,  40'h0};

        fu_v[0] = 40'h1408;
        for (int i = 0; i < 13; i++) begin
            rst   = tbl[i].rst;
            ready = tbl[i].ready;
            ack_v = tbl[i].ack;
            step();
            chk($sformatf("tbl%0d_valid", i),  64'(d_valid),       64'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_wfid", i),   64'(d_wfid[0]),     64'(tbl[i].exp_wfid));
            chk($sformatf("tbl%0d_issued", i), 64'(bus.wf_issued), 64'(tbl[i].exp_issued));
        end

        // SALU wrap: issue 38 first so the pointer sits at 39, then expect 39, 0, 5.
        do_reset();
        fu_v[2] = (40'h1 << 38) | (40'h1 << 39) | 40'h1 | (40'h1 << 5);
        ready   = 40'h1 << 38;
        step();
        chk("wrap_first", 64'(d_wfid[2]), 64'd38);
        ready   = fu_v[2];
        ack_v   = 4'h4;
        step();
        chk("wrap_39", 64'(d_wfid[2]), 64'd39);
        chk("wrap_iss38", 64'(bus.wf_issued), 64'(40'h1 << 38));
        step();
        chk("wrap_0", 64'(d_wfid[2]), 64'd0);
        chk("wrap_iss39", 64'(bus.wf_issued), 64'(40'h1 << 39));
        step();
        chk("wrap_5", 64'(d_wfid[2]), 64'd5);
        chk("wrap_iss0", 64'(bus.wf_issued), 64'h1);
        step();
        chk("wrap_idle", 64'(d_valid[2]), 64'd0);
        chk("wrap_iss5", 64'(bus.wf_issued), 64'h20);

        // LSU hold: offer of 7 stays put while ready drops and ack is low.
        do_reset();
        fu_v[3] = 40'h80;
        ready   = 40'h80;
        step();
        chk("hold_offer", 64'(d_wfid[3]), 64'd7);
        ready = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("hold_valid%0d", c), 64'(d_valid[3]), 64'd1);
            chk($sformatf("hold_wfid%0d", c), 64'(d_wfid[3]), 64'd7);
        end
        chk("hold_stall", 64'(d_stall[3]), STALL_EN ? 64'd5 : 64'd0);
        ack_v = 4'h8;
        step();
        chk("hold_release", 64'(bus.wf_issued), 64'h80);
        chk("hold_idle", 64'(d_valid[3]), 64'd0);

        // SIMF no re-issue while ready lingers one cycle after the pulse.
        do_reset();
        fu_v[1] = 40'h1000;
        ready   = 40'h1000;
        ack_v   = 4'h2;
        step();
        chk("noreiss_offer", 64'(d_wfid[1]), 64'd12);
        step();
        chk("noreiss_iss", 64'(bus.wf_issued), 64'h1000);
        chk("noreiss_idle", 64'(d_valid[1]), 64'd0);
        step();
        chk("noreiss_still_idle", 64'(d_valid[1]), 64'd0);
        ready = '0;
        step();

        // All four lanes in one cycle.
        do_reset();
        fu_v  = '0;
        fu_v[0] = 40'h2; fu_v[1] = 40'h4; fu_v[2] = 40'h8; fu_v[3] = 40'h10;
        ready = 40'h1E;
        ack_v = 4'hF;
        step();
        chk("simul_valid", 64'(d_valid), 64'hF);
        step();
        chk("simul_iss", 64'(bus.wf_issued), 64'h1E);
        chk("simul_idle", 64'(d_valid), 64'h0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                fu_v = '0;
                for (int i = 0; i < 40; i++) begin
                    int ln;
                    ln = int'($urandom_range(0, 4));
                    if (ln < 4) fu_v[ln][i] = 1'b1;
                end
            end
            ready = {8'($urandom()), $urandom()} | {8'($urandom()), $urandom()};
            ack_v = 4'($urandom());
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
